ps2_keyboard_emulator: RTL and testbench

Parametrised PS/2 keyboard device model for the simulation benches. It takes single-cycle key events (scan code plus release/extended qualifiers), expands them into PS/2 byte sequences, and buffers those bytes in a FIFO. Bytes are serialised onto ps2_clk/ps2_dat as device-to-host frames. Lock-key state (Caps/Num/Scroll) is tracked internally and exported as ps2_lock_control, feeding the lock indicators in the GUI.

---
 rtl/ps2_keyboard_emulator.sv | 191 +++++++++++++++++++
 tb/tb_ps2_keyboard_emulator.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_emulator.sv
// PS/2 keyboard device model: expands key events into make/break byte sequences,
// queues them in a byte FIFO and serialises them as device-to-host PS/2 frames.
module ps2_keyboard_emulator #(
    parameter int CLK_DIV    = 2500,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             key_action,
    input  logic [7:0]       scan_code,
    input  logic             key_release,
    input  logic             key_extended,
    output logic             ps2_clk,
    output logic             ps2_dat,
    output logic [2:0]       ps2_lock_control,
    output logic             overflow,
    output logic             busy,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int DIV_W = $clog2(2 * CLK_DIV) + 1;

    typedef enum logic [2:0] {IDLE, LOAD, BIT_HI, BIT_LO, GAP} state_t;

    function automatic logic [10:0] make_frame(input logic [7:0] d);
        return {1'b1, ~^d, d, 1'b0};
    endfunction

    state_t           r_state;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CNT_W-1:0] r_count;
    logic [2:0]       r_lock;
    logic             r_overflow;
    logic [DIV_W-1:0] r_div;
    logic [3:0]       r_bit;
    logic [10:0]      r_frame;
    logic             r_clk_p0;
    logic             r_dat_p0;
    logic             r_ps2_clk;
    logic             r_ps2_dat;

    logic [7:0]       w_bytes [3];
    logic [1:0]       w_n;
    logic [CNT_W-1:0] w_free;
    logic             w_accept;
    logic             w_half_end;
    logic             w_gap_end;
    logic             w_pop;

    always_comb begin
        w_bytes[0] = scan_code;
        w_bytes[1] = 8'h00;
        w_bytes[2] = 8'h00;
        w_n        = 2'd1;
        if (key_extended && key_release) begin
            w_bytes[0] = 8'hE0;
            w_bytes[1] = 8'hF0;
            w_bytes[2] = scan_code;
            w_n        = 2'd3;
        end else if (key_extended || key_release) begin
            w_bytes[0] = key_extended ? 8'hE0 : 8'hF0;
            w_bytes[1] = scan_code;
            w_n        = 2'd2;
        end
    end

    // Free space is judged on the pre-pop count so an event never relies on a same-edge pop.
    assign w_free     = CNT_W'(FIFO_DEPTH) - r_count;
    assign w_accept   = key_action && (w_free >= CNT_W'(w_n));
    assign w_half_end = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_gap_end  = (r_div == DIV_W'(2 * CLK_DIV - 1));
    assign w_pop      = (r_count != '0) &&
                        ((r_state == IDLE) || ((r_state == GAP) && w_gap_end));

    always_ff @(posedge CLOCK_50) begin
        if (w_accept) begin
            for (int i = 0; i < 3; i++) begin
                if (i < int'(w_n)) r_mem[r_wr + AW'(i)] <= w_bytes[i];
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state    <= IDLE;
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_lock     <= '0;
            r_overflow <= 1'b0;
            r_div      <= '0;
            r_bit      <= '0;
            r_clk_p0   <= 1'b1;
            r_dat_p0   <= 1'b1;
            r_ps2_clk  <= 1'b1;
            r_ps2_dat  <= 1'b1;
        end else begin
            r_overflow <= key_action && !w_accept;
            if (w_accept) r_wr <= r_wr + AW'(w_n);
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_count <= r_count + (w_accept ? CNT_W'(w_n) : CNT_W'(0))
                               - (w_pop ? CNT_W'(1) : CNT_W'(0));

            if (w_accept && !key_release && !key_extended) begin
                case (scan_code)
                    8'h58:   r_lock[2] <= ~r_lock[2];
                    8'h77:   r_lock[1] <= ~r_lock[1];
                    8'h7E:   r_lock[0] <= ~r_lock[0];
                    default: ;
                endcase
            end

            case (r_state)
                IDLE: begin
                    r_clk_p0 <= 1'b1;
                    r_dat_p0 <= 1'b1;
                    r_div    <= '0;
                    if (r_count != '0) begin
                        r_frame <= {3'b000, r_mem[r_rd]};
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_frame  <= make_frame(r_frame[7:0]);
                    r_dat_p0 <= 1'b0;
                    r_bit    <= '0;
                    r_div    <= '0;
                    r_state  <= BIT_HI;
                end
                BIT_HI: begin
                    if (w_half_end) begin
                        r_div    <= '0;
                        r_clk_p0 <= 1'b0;
                        r_state  <= BIT_LO;
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                BIT_LO: begin
                    if (w_half_end) begin
                        r_div    <= '0;
                        r_clk_p0 <= 1'b1;
                        if (r_bit == 4'd10) begin
                            r_dat_p0 <= 1'b1;
                            r_state  <= GAP;
                        end else begin
                            r_bit    <= r_bit + 4'd1;
                            r_frame  <= {1'b0, r_frame[10:1]};
                            r_dat_p0 <= r_frame[1];
                            r_state  <= BIT_HI;
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                GAP: begin
                    if (w_gap_end) begin
                        r_div <= '0;
                        // Chain straight into the next start bit to keep a 24-half-period byte rate.
                        if (r_count != '0) begin
                            r_frame  <= make_frame(r_mem[r_rd]);
                            r_dat_p0 <= 1'b0;
                            r_bit    <= '0;
                            r_state  <= BIT_HI;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase

            r_ps2_clk <= r_clk_p0;
            r_ps2_dat <= r_dat_p0;
        end
    end

    assign ps2_clk          = r_ps2_clk;
    assign ps2_dat          = r_ps2_dat;
    assign ps2_lock_control = r_lock;
    assign overflow         = r_overflow;
    assign busy             = (r_state != IDLE) || (r_count != '0);
    assign fifo_count       = r_count;

endmodule

// File: tb/tb_ps2_keyboard_emulator.sv
// Directed bench for ps2_keyboard_emulator: a line monitor decodes frames from
// falling edges of ps2_clk and the stimulus compares against hand-derived values.
module tb_ps2_keyboard_emulator;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

    logic             CLOCK_50 = 1'b0;
    logic             reset = 1'b1;
    logic             key_action = 1'b0;
    logic [7:0]       scan_code = 8'h00;
    logic             key_release = 1'b0;
    logic             key_extended = 1'b0;
    logic             ps2_clk;
    logic             ps2_dat;
    logic [2:0]       ps2_lock_control;
    logic             overflow;
    logic             busy;
    logic [CNT_W-1:0] fifo_count;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] mon_byte [$];
    logic       mon_start [$];
    logic       mon_par [$];
    logic       mon_stop [$];
    int         mon_t [$];

    ps2_keyboard_emulator #(
        .CLK_DIV(CLK_DIV),
        .FIFO_DEPTH(FIFO_DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .key_action(key_action),
        .scan_code(scan_code),
        .key_release(key_release),
        .key_extended(key_extended),
        .ps2_clk(ps2_clk),
        .ps2_dat(ps2_dat),
        .ps2_lock_control(ps2_lock_control),
        .overflow(overflow),
        .busy(busy),
        .fifo_count(fifo_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Line monitor: sample ps2_dat on each falling ps2_clk, 11 bits per frame.
    initial begin
        int         cyc;
        int         bitcnt;
        int         t_first;
        logic       prev;
        logic [10:0] sh;
        cyc = 0; bitcnt = 0; t_first = 0; prev = 1'b1; sh = '0;
        forever begin
            @(negedge CLOCK_50);
            cyc++;
            if (reset) begin
                bitcnt = 0;
                prev   = 1'b1;
            end else begin
                if (prev && !ps2_clk) begin
                    if (bitcnt == 0) t_first = cyc;
                    sh[bitcnt] = ps2_dat;
                    bitcnt++;
                    if (bitcnt == 11) begin
                        mon_start.push_back(sh[0]);
                        mon_byte.push_back(sh[8:1]);
                        mon_par.push_back(sh[9]);
                        mon_stop.push_back(sh[10]);
                        mon_t.push_back(t_first);
                        bitcnt = 0;
                    end
                end
                prev = ps2_clk;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    // Returns at the negedge right after the sampling edge.
    task automatic send_key(input logic [7:0] code, input logic rel, input logic ext);
        @(negedge CLOCK_50);
        key_action   = 1'b1;
        scan_code    = code;
        key_release  = rel;
        key_extended = ext;
        @(negedge CLOCK_50);
        key_action   = 1'b0;
        key_release  = 1'b0;
        key_extended = 1'b0;
    endtask

    task automatic wait_bytes(input int target, input int budget);
        int k;
        k = 0;
        while (mon_byte.size() < target && k < budget) begin
            @(negedge CLOCK_50);
            k++;
        end
        chk("byte_count", mon_byte.size(), target);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            @(negedge CLOCK_50);
            k++;
        end
        chk("idle", busy, 0);
    endtask

    task automatic chk_frame(input int idx, input logic [7:0] b, input logic par);
        chk("frame_byte", mon_byte[idx], b);
        chk("frame_start", mon_start[idx], 0);
        chk("frame_parity", mon_par[idx], par);
        chk("frame_stop", mon_stop[idx], 1);
    endtask

    initial begin
        int base;

        // Reset state
        wait_cyc(2);
        chk("rst_clk", ps2_clk, 1);
        chk("rst_dat", ps2_dat, 1);
        chk("rst_lock", ps2_lock_control, 3'b000);
        chk("rst_ovf", overflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", fifo_count, 0);
        reset = 1'b0;
        wait_cyc(3);

        // Single make 1C: latency, timing, frame content
        base = mon_byte.size();
        send_key(8'h1C, 1'b0, 1'b0);
        chk("t1_count", fifo_count, 1);
        chk("t1_busy", busy, 1);
        wait_cyc(2);
        chk("t1_dat_n2", ps2_dat, 1);
        wait_cyc(1);
        chk("t1_dat_n3", ps2_dat, 0);
        chk("t1_clk_n3", ps2_clk, 1);
        wait_cyc(3);
        chk("t1_clk_n6", ps2_clk, 1);
        wait_cyc(1);
        chk("t1_clk_n7", ps2_clk, 0);
        wait_cyc(90);
        chk("t1_busy_n97", busy, 1);
        wait_cyc(1);
        chk("t1_busy_n98", busy, 0);
        chk("t1_idle_clk", ps2_clk, 1);
        chk("t1_idle_dat", ps2_dat, 1);
        wait_bytes(base + 1, 50);
        chk_frame(base, 8'h1C, 1'b0);
        chk("t1_lock", ps2_lock_control, 3'b000);

        // Extended release of 75: E0 F0 75
        wait_cyc(3);
        base = mon_byte.size();
        send_key(8'h75, 1'b1, 1'b1);
        chk("t2_count", fifo_count, 3);
        wait_bytes(base + 3, 400);
        chk_frame(base, 8'hE0, 1'b0);
        chk_frame(base + 1, 8'hF0, 1'b1);
        chk_frame(base + 2, 8'h75, 1'b0);
        chk("t2_period_a", mon_t[base + 1] - mon_t[base], 96);
        chk("t2_period_b", mon_t[base + 2] - mon_t[base + 1], 96);
        chk("t2_lock", ps2_lock_control, 3'b000);
        wait_idle(100);

        // Lock tracking
        send_key(8'h58, 1'b0, 1'b0);
        chk("t3_caps_make", ps2_lock_control, 3'b100);
        wait_idle(200);
        send_key(8'h58, 1'b1, 1'b0);
        chk("t3_caps_break", ps2_lock_control, 3'b100);
        wait_idle(300);
        send_key(8'h58, 1'b0, 1'b0);
        chk("t3_caps_again", ps2_lock_control, 3'b000);
        wait_idle(200);
        send_key(8'h58, 1'b0, 1'b1);
        chk("t3_ext_58", ps2_lock_control, 3'b000);
        wait_idle(300);
        send_key(8'h77, 1'b0, 1'b0);
        chk("t3_num", ps2_lock_control, 3'b010);
        wait_idle(200);
        send_key(8'h7E, 1'b0, 1'b0);
        chk("t3_scroll", ps2_lock_control, 3'b011);
        wait_idle(200);

        // Overflow: fill FIFO behind an active frame, then a 3-byte event
        base = mon_byte.size();
        send_key(8'h16, 1'b0, 1'b0);
        send_key(8'h1E, 1'b0, 1'b0);
        send_key(8'h26, 1'b0, 1'b0);
        send_key(8'h25, 1'b0, 1'b0);
        send_key(8'h2E, 1'b0, 1'b0);
        chk("t4_full", fifo_count, 4);
        chk("t4_no_ovf", overflow, 0);
        send_key(8'h75, 1'b1, 1'b1);
        chk("t4_ovf", overflow, 1);
        chk("t4_count_kept", fifo_count, 4);
        wait_cyc(1);
        chk("t4_ovf_pulse", overflow, 0);
        wait_bytes(base + 5, 700);
        chk("t4_b0", mon_byte[base], 8'h16);
        chk("t4_b1", mon_byte[base + 1], 8'h1E);
        chk("t4_b2", mon_byte[base + 2], 8'h26);
        chk("t4_b3", mon_byte[base + 3], 8'h25);
        chk("t4_b4", mon_byte[base + 4], 8'h2E);
        wait_idle(200);
        chk("t4_no_extra", mon_byte.size(), base + 5);

        // Reset 30 cycles into a frame, with more bytes queued and locks set
        send_key(8'h1C, 1'b0, 1'b0);
        send_key(8'h1C, 1'b1, 1'b0);
        wait_cyc(31);
        @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        chk("t5_clk", ps2_clk, 1);
        chk("t5_dat", ps2_dat, 1);
        chk("t5_count", fifo_count, 0);
        chk("t5_lock", ps2_lock_control, 3'b000);
        chk("t5_busy", busy, 0);
        @(negedge CLOCK_50);
        reset = 1'b0;
        wait_cyc(2);
        base = mon_byte.size();
        send_key(8'h1C, 1'b0, 1'b0);
        wait_cyc(2);
        chk("t5_dat_n2", ps2_dat, 1);
        wait_cyc(1);
        chk("t5_dat_n3", ps2_dat, 0);
        wait_bytes(base + 1, 150);
        chk_frame(base, 8'h1C, 1'b0);
        wait_idle(100);
        chk("t5_single", mon_byte.size(), base + 1);

        // Two consecutive key_action cycles: 1C then 32
        base = mon_byte.size();
        @(negedge CLOCK_50);
        key_action = 1'b1;
        scan_code  = 8'h1C;
        @(negedge CLOCK_50);
        chk("t6_count_a", fifo_count, 1);
        scan_code  = 8'h32;
        @(negedge CLOCK_50);
        key_action = 1'b0;
        chk("t6_count_b", fifo_count, 1);
        wait_bytes(base + 2, 300);
        chk_frame(base, 8'h1C, 1'b0);
        chk_frame(base + 1, 8'h32, 1'b0);
        chk("t6_period", mon_t[base + 1] - mon_t[base], 96);
        wait_idle(100);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
